// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared requester ids and owner-pipeline entry type
package ram_arbiter_pkg;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } owner_t;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// rtl/ram_arbiter_rr_pick2.sv - two-input round-robin grant picker
module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (req[REQ_A] && (!req[REQ_B] || ptr == REQ_A)) begin
        gnt[REQ_A] = 1'b1;
      end else if (req[REQ_B]) begin
        gnt[REQ_B] = 1'b1;
      end
    end
  end

  // Pointer always favours whoever was not granted last.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= REQ_A;
    end else if (gnt[REQ_A]) begin
      ptr <= REQ_B;
    end else if (gnt[REQ_B]) begin
      ptr <= REQ_A;
    end
  end

endmodule

// File: rtl/synchro_ram.sv
// rtl/synchro_ram.sv - single-port RAM with 1-cycle synchronous read and synchronous write
module synchro_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (write) begin
      mem[addr] <= datain;
    end
    dataout <= read ? mem[addr] : '0;
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin sequencer sharing one synchronous RAM between requesters A and B
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_datain,
  input  logic [DATA_W-1:0] ram_dataout
);

  logic [1:0]        gnt;
  logic              any_gnt;
  logic              sel_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  owner_t            own0;
  owner_t            own1;

  rr_pick2 u_pick (
    .clk (clk),
    .rst (rst),
    .req ({b_req, a_req}),
    .gnt (gnt)
  );

  assign a_gnt     = gnt[REQ_A];
  assign b_gnt     = gnt[REQ_B];
  assign any_gnt   = |gnt;
  assign sel_b     = gnt[REQ_B];
  assign sel_we    = sel_b ? b_we    : a_we;
  assign sel_addr  = sel_b ? b_addr  : a_addr;
  assign sel_wdata = sel_b ? b_wdata : a_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_read   <= 1'b0;
      ram_write  <= 1'b0;
      ram_addr   <= '0;
      ram_datain <= '0;
    end else begin
      ram_read  <= any_gnt & ~sel_we;
      ram_write <= any_gnt & sel_we;
      if (any_gnt) begin
        ram_addr   <= sel_addr;
        ram_datain <= sel_wdata;
      end
    end
  end

  // own0 covers the RAM command cycle, own1 the cycle ram_dataout is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      own0 <= '0;
      own1 <= '0;
    end else begin
      own0.valid <= any_gnt & ~sel_we;
      own0.id    <= sel_b;
      own1       <= own0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= own1.valid && (own1.id == REQ_A);
      b_rvalid <= own1.valid && (own1.id == REQ_B);
      if (own1.valid && own1.id == REQ_A) begin
        a_rdata <= ram_dataout;
      end
      if (own1.valid && own1.id == REQ_B) begin
        b_rdata <= ram_dataout;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter driving a synchro_ram
module tb_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_read, ram_write;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_datain, ram_dataout;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_datain(ram_datain), .ram_dataout(ram_dataout)
  );

  synchro_ram #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
    .clk(clk), .read(ram_read), .write(ram_write), .addr(ram_addr),
    .datain(ram_datain), .dataout(ram_dataout)
  );

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] model [16];
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic record(input logic id, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata);
    if (we) model[addr] = wdata;
    else    q.push_back('{id: id, data: model[addr], due: cyc + 3});
  endtask

  // Holds req until granted; returns the number of cycles spent waiting.
  task automatic access(input logic id, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, output int waited);
    logic granted;
    granted = 1'b0;
    waited  = 0;
    if (id) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
    else    begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
    while (!granted && waited < 10) begin
      @(negedge clk);
      if (id ? b_gnt : a_gnt) granted = 1'b1;
      else waited++;
    end
    if (!granted) chk("gnt_timeout", 0, 1);
    else record(id, we, addr, wdata);
    @(posedge clk); #1;
    if (id) b_req = 0; else a_req = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (a_gnt | b_gnt) chk("one_gnt", a_gnt & b_gnt, 0);
      if (ram_read | ram_write) chk("one_strobe", ram_read & ram_write, 0);
      while (q.size() > 0 && q[0].due < cyc) begin
        chk("missing_rvalid", 0, 1);
        void'(q.pop_front());
      end
      if (a_rvalid || b_rvalid) begin
        if (q.size() == 0) begin
          chk("unexpected_rvalid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rvalid_onehot", a_rvalid & b_rvalid, 0);
          chk("rvalid_owner", b_rvalid, e.id);
          chk("rdata", e.id ? b_rdata : a_rdata, e.data);
          chk("read_latency", cyc, e.due);
          if (e.id) last_b = e.data; else last_a = e.data;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int wa, wb;
    rst = 1; a_req = 1; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    idle(2);
    @(negedge clk);
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_ram_read", ram_read, 0);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_datain", ram_datain, 0);
    chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    chk("rst_rdata", {a_rdata, b_rdata}, 0);
    @(posedge clk); #1;
    rst = 0; a_req = 0;

    // A writes 3 = 0xA, then reads it back
    access(0, 1, 3, 4'hA, wa); chk("t1_wr_wait", wa, 0);
    access(0, 0, 3, 4'h0, wa); chk("t1_rd_wait", wa, 0);
    idle(5);

    // preload words, reset, then simultaneous reads
    access(0, 1, 1, 4'h5, wa);
    access(1, 1, 2, 4'h9, wb);
    idle(4);
    rst = 1; idle(1); rst = 0;
    fork
      access(0, 0, 1, 4'h0, wa);
      access(1, 0, 2, 4'h0, wb);
    join
    chk("t2_a_wait", wa, 0);
    chk("t2_b_wait", wb, 1);
    idle(5);

    // continuous contention: strict alternation starting with A
    a_req = 1; a_we = 0; a_addr = 1;
    b_req = 1; b_we = 0; b_addr = 2;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("alt_a_gnt", a_gnt, (i % 2) == 0);
      chk("alt_b_gnt", b_gnt, (i % 2) == 1);
      if (a_gnt) record(0, 0, 1, 0);
      if (b_gnt) record(1, 0, 2, 0);
      @(posedge clk); #1;
    end
    a_req = 0; b_req = 0;
    idle(6);

    // read-after-write on consecutive grants
    access(1, 1, 5, 4'h6, wb); chk("t4_wr_wait", wb, 0);
    access(0, 0, 5, 4'h0, wa); chk("t4_rd_wait", wa, 0);
    idle(6);

    // reset one cycle after a read grant drops the read
    access(0, 0, 5, 4'h0, wa);
    void'(q.pop_back());
    rst = 1; a_req = 1;
    idle(1);
    @(negedge clk);
    chk("t5_rst_gnt", a_gnt, 0);
    chk("t5_rst_strobes", {ram_read, ram_write}, 0);
    chk("t5_rst_addr", ram_addr, 0);
    chk("t5_rst_datain", ram_datain, 0);
    chk("t5_rst_rvalid", {a_rvalid, b_rvalid}, 0);
    chk("t5_rst_rdata", {a_rdata, b_rdata}, 0);
    @(posedge clk); #1;
    rst = 0; a_req = 0;
    last_a = '0; last_b = '0;
    access(1, 0, 2, 4'h0, wb); chk("t5_b_wait", wb, 0);
    idle(5);

    // idle: strobes low, address and read data hold
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_strobes", {ram_read, ram_write}, 0);
      chk("idle_addr", ram_addr, 2);
      chk("idle_a_rdata", a_rdata, 0);
      chk("idle_b_rdata", b_rdata, 4'h9);
    end

    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port round-robin arbiter and sequencer that shares one synchronous single-port RAM (16 words x 4 bits) between requesters A and B.
- Accepts at most one access per cycle and drives the RAM's registered command interface.
- Tracks which requester owns each in-flight read and returns read data with a per-requester valid strobe.
- Sits between two client blocks and the synchro-style RAM, which has 1-cycle synchronous read and synchronous write.

Parameters:
- ADDR_W, 4, RAM address width; depth is 2**ADDR_W.
- DATA_W, 4, RAM data width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  requester A access request; held until a_gnt.
- a_we  in  1  A: 1 = write, 0 = read; stable while a_req is high.
- a_addr  in  ADDR_W  A address.
- a_wdata  in  DATA_W  A write data.
- a_gnt  out  1  combinational; A's request is accepted this cycle.
- a_rvalid  out  1  registered; a_rdata is valid this cycle.
- a_rdata  out  DATA_W  read data returned to A.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B.
- ram_read  out  1  registered read strobe to RAM.
- ram_write  out  1  registered write strobe to RAM.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_datain  out  DATA_W  registered RAM write data.
- ram_dataout  in  DATA_W  RAM read data, valid the cycle after the edge that samples ram_read.

Behaviour:
- Reset (rst high at posedge): ram_read, ram_write, a_rvalid and b_rvalid go to 0; ram_addr, ram_datain, a_rdata and b_rdata go to 0; priority pointer points to A; in-flight read tracking is cleared.
- Reset mid-operation: reads already issued produce no rvalid. a_gnt and b_gnt are 0 while rst is high.
- Arbitration in cycle N:
  - Only A requests: grant A.
  - Only B requests: grant B.
  - Both request: grant the requester the pointer favours; the pointer then moves to the other requester.
  - Pointer updates only on a grant under contention or a single grant, and always points to the requester not granted last.
- Never both grants in one cycle. A requester not granted keeps req asserted; it is guaranteed a grant within 2 cycles (no starvation).
- Issue in cycle N+1: on a grant, the granted addr and wdata are registered into ram_addr and ram_datain.
  - ram_write = granted we.
  - ram_read = ~granted we.
  - ram_read and ram_write are never both 1.
  - No grant: both strobes are 0; ram_addr and ram_datain hold their values.
- Write completes at the posedge ending N+1.
- Read data returns in cycle N+2: ram_dataout is captured into x_rdata and x_rvalid is pulsed for exactly 1 cycle in N+3. Read latency is grant to rvalid = 3 cycles.
- A 2-stage owner shift register (valid, id) tracks in-flight reads. x_rdata holds its value between pulses.
- Throughput: 1 access/cycle. Back-to-back reads from different requesters return in grant order.
- Read-after-write, same address, consecutive grants: the read returns the new data. The RAM memory updates at the write edge, before the read edge.
- The RAM drives 0 on dataout when read was low. The arbiter ignores ram_dataout unless its owner pipeline is valid.

Decomposition:
- Shared package: requester-id constants (REQ_A = 0, REQ_B = 1) and the owner-pipeline entry struct/typedef {valid, id}.
- One natural sub-module, rr_pick2: a 2-input round-robin grant picker with a pointer register.
- Owner tracking and command registers stay in ram_arbiter.
- Bench instantiates ram_arbiter with synchro_ram.

Test Plan:
- Reset, then A writes addr 3 data 0xA; A reads addr 3 -> a_gnt high the same cycle as each request; a_rvalid pulses 3 cycles after the read grant with a_rdata = 0xA; b_rvalid stays 0.
- A and B both request reads (A addr 1, B addr 2) held high from the same cycle after reset -> A granted first, B the next cycle; a_rvalid and b_rvalid are on consecutive cycles with the correct preloaded words.
- A and B continuously request for 8 cycles -> grants strictly alternate A,B,A,B...; no cycle has both grants.
- B writes addr 5 = 0x6, and A reads addr 5 on the very next grant -> a_rdata = 0x6.
- Issue a read from A, then assert rst 1 cycle after the grant -> no a_rvalid; all outputs 0; after release, a single B request is granted immediately.
- Idle cycles -> ram_read = ram_write = 0; ram_addr holds its last value; rdata outputs hold.
